pipe_scroller: RTL
==================

PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 The block SHALL have parameter SPACING, default 160, meaning horizontal pitch in pixels between adjacent pipe slots.
REQ-002 The block SHALL have parameter PIPE_W, default 40, meaning pipe width in pixels.
REQ-003 The block SHALL have parameter SPEED, default 2, meaning base scroll step in pixels per frame tick, legal range 1..SPACING-1.
REQ-004 The block SHALL have a single clock domain and an asynchronous, active-high reset, with ports named clk and rst.
REQ-005 Ports SHALL be:
  - clk  input  1  system clock.
  - rst  input  1  async active-high reset.
  - frame_tick  input  1  one-cycle pulse per video frame.
  - start  input  1  one-cycle pulse that starts or restarts play.
  - crash  input  1  level, collision detected by obstacle logic.
  - rom_index  output  3  rotation index 0..4 driven to the pipe-height ROM.
  - x_base  output  10  right edge of pipe slot 0; slot k right edge = x_base + k*SPACING.
  - score  output  8  pipes cleared, saturating.
  - wrap_pulse  output  1  one-cycle pulse on each slot wrap.
  - running  output  1  high in RUN.
  - dead  output  1  high in DEAD.

Function
REQ-006 The FSM SHALL have states IDLE, RUN and DEAD.
  - IDLE->RUN on start.
  - RUN->DEAD on crash.
  - DEAD->IDLE on start.
  - All other inputs hold the current state.
REQ-007 Entering IDLE from DEAD SHALL reload x_base=SPACING, rom_index=0, score=0 and the speed to SPEED, all in the same edge as the transition.
REQ-008 In RUN, on frame_tick with crash low:
  - if x_base > step, x_base SHALL become x_base-step;
  - otherwise it SHALL wrap: x_base becomes x_base+SPACING-step, rom_index advances, score increments, and wrap_pulse asserts.
REQ-009 x_base SHALL never be 0 or exceed SPACING; all arithmetic SHALL be unsigned 10-bit, with no underflow.
REQ-010 rom_index SHALL count 0,1,2,3,4,0 on wraps and SHALL never present values 5..7.
REQ-011 score SHALL saturate at 255; a wrap at 255 still pulses wrap_pulse.
REQ-012 When crash and frame_tick occur in the same RUN cycle, crash SHALL win: DEAD is entered and x_base, rom_index and score are unchanged.
REQ-013 In IDLE and DEAD, frame_tick SHALL have no effect, and crash SHALL be ignored outside RUN.
REQ-014 All outputs SHALL be registered, so updates are visible the cycle after the triggering edge (latency 1).
REQ-015 wrap_pulse SHALL be high for exactly one cycle per wrap and low otherwise.

Reset
REQ-016 While rst is high, the block SHALL hold state=IDLE, x_base=SPACING, rom_index=0, score=0, wrap_pulse=0, running=0, dead=0 and step=SPEED, independent of clk.
REQ-017 Reset asserted mid-RUN SHALL abort immediately, and play SHALL resume only after a new start.

Configuration
REQ-018 With PIPE_SCROLL_SPEEDUP_EN defined, step SHALL begin at SPEED and increase by 1 after every 8th wrap, capped at min(4, SPACING-1).
REQ-019 Without PIPE_SCROLL_SPEEDUP_EN, step SHALL be the constant SPEED, and the wrap-group counter SHALL not exist.

Structure
REQ-020 The FSM state encoding and the defaults for SPACING, PIPE_W, SPEED and the max step SHALL live in shared package flappy_pkg, which is also used by the renderer and the obstacle logic.
REQ-021 The rotation counter SHALL be a sub-module mod5_counter (clk, rst, clr, inc -> q[2:0]), instantiated once.

Verification
REQ-022 Reset then start, with 3 frame_ticks at SPEED=2 -> x_base 160->158->156->154, rom_index=0, running=1.
REQ-023 RUN with x_base=2 and a frame_tick -> x_base=160, rom_index 0->1, score+1, wrap_pulse high for exactly one cycle.
REQ-024 Five consecutive wraps from rom_index=0 -> rom_index sequence 1,2,3,4,0 and score=5.
REQ-025 crash and frame_tick in the same cycle at x_base=100 -> dead=1, x_base stays 100; a later start -> IDLE with x_base=160, score=0, rom_index=0.
REQ-026 rst asserted asynchronously mid-RUN (between clk edges) at x_base=50, score=7 -> outputs at reset values before the next clk edge.
REQ-027 With PIPE_SCROLL_SPEEDUP_EN, 8 wraps -> step becomes 3 (x_base decrements by 3); after 24 wraps, step stays 4.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared game constants and FSM encoding for the scroller, renderer and
// obstacle logic.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int SPACING_DEF = 160;
    localparam int PIPE_W_DEF  = 40;
    localparam int SPEED_DEF   = 2;
    localparam int STEP_MAX    = 4;

endpackage

// File: rtl/mod5_counter.sv
// Pipe-height ROM rotation counter: 0,1,2,3,4,0 on each increment.
// Synchronous clear has priority over increment.
module mod5_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 3'd0;
        end else if (clr) begin
            q <= 3'd0;
        end else if (inc) begin
            q <= (q == 3'd4) ? 3'd0 : q + 3'd1;
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Pipe scroller: IDLE/RUN/DEAD play FSM, slot position, score and rotation.
// Define PIPE_SCROLL_SPEEDUP_EN to raise the step by 1 every 8th wrap.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int SPACING = SPACING_DEF,
    parameter int PIPE_W  = PIPE_W_DEF,
    parameter int SPEED   = SPEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       crash,
    output logic [2:0] rom_index,
    output logic [9:0] x_base,
    output logic [7:0] score,
    output logic       wrap_pulse,
    output logic       running,
    output logic       dead
);

    localparam logic [9:0] SP  = 10'(SPACING);
    localparam logic [9:0] SPD = 10'(SPEED);

    if (SPEED < 1 || SPEED >= SPACING || PIPE_W >= SPACING) begin : g_bad_cfg
        $error("pipe_scroller: illegal SPEED/PIPE_W for SPACING");
    end

    state_t     state;
    logic [9:0] step;
    logic       adv;
    logic       wrap;
    logic       reload;

    assign adv    = (state == ST_RUN) && frame_tick && !crash;
    assign wrap   = adv && (x_base <= step);
    assign reload = (state == ST_DEAD) && start;

    mod5_counter u_rot (
        .clk (clk),
        .rst (rst),
        .clr (reload),
        .inc (wrap),
        .q   (rom_index)
    );

`ifdef PIPE_SCROLL_SPEEDUP_EN
    localparam int         CAP_I = (STEP_MAX < SPACING - 1) ? STEP_MAX : SPACING - 1;
    localparam logic [9:0] CAP   = 10'(CAP_I);

    logic [2:0] grp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= SPD;
            grp  <= 3'd0;
        end else if (reload) begin
            step <= SPD;
            grp  <= 3'd0;
        end else if (wrap) begin
            grp <= grp + 3'd1;
            if (grp == 3'd7 && step < CAP) begin
                step <= step + 10'd1;
            end
        end
    end
`else
    assign step = SPD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            x_base     <= SP;
            score      <= 8'd0;
            wrap_pulse <= 1'b0;
            running    <= 1'b0;
            dead       <= 1'b0;
        end else begin
            wrap_pulse <= wrap;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (crash) begin
                        state   <= ST_DEAD;
                        running <= 1'b0;
                        dead    <= 1'b1;
                    end else if (frame_tick) begin
                        // x_base <= step here, so the sum stays within 1..SPACING
                        if (wrap) begin
                            x_base <= x_base + SP - step;
                            if (score != 8'hFF) score <= score + 8'd1;
                        end else begin
                            x_base <= x_base - step;
                        end
                    end
                end
                ST_DEAD: begin
                    if (start) begin
                        state  <= ST_IDLE;
                        dead   <= 1'b0;
                        x_base <= SP;
                        score  <= 8'd0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    dead    <= 1'b0;
                end
            endcase
        end
    end

endmodule
